// File: rtl/vit_logits_argmax_if.sv
// Start/done handshake between the top-level controller (initiator) and the
// logits argmax responder: request, logits vector and top-1 result.
interface vit_logits_argmax_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 1000,
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
);
    logic                              start;
    logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_in;
    logic                              busy;
    logic                              done;
    logic                              out_valid;
    logic [IDX_W-1:0]                  class_idx;
    logic [DATA_WIDTH-1:0]             max_val;

    modport master (
        output start,
        output logits_in,
        input  busy,
        input  done,
        input  out_valid,
        input  class_idx,
        input  max_val
    );

    modport slave (
        input  start,
        input  logits_in,
        output busy,
        output done,
        output out_valid,
        output class_idx,
        output max_val
    );
endinterface

// File: rtl/vit_logits_argmax.sv
// Top-1 responder: captures a logits vector on start, scans one class per
// cycle with a strict signed compare, and reports the winning index/value.
module vit_logits_argmax #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 1000,
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    vit_logits_argmax_if.slave bus
);
    localparam int               VEC_W    = DATA_WIDTH * NUM_CLASSES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam bit               MULTI    = (NUM_CLASSES > 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [VEC_W-1:0]              r_logits;
    logic [VEC_W-1:0]              w_logits_next;
    logic [IDX_W-1:0]              r_cnt;
    logic [IDX_W-1:0]              w_cnt_next;
    logic [IDX_W-1:0]              r_best_idx;
    logic [IDX_W-1:0]              w_best_idx_next;
    logic signed [DATA_WIDTH-1:0]  r_best_val;
    logic signed [DATA_WIDTH-1:0]  w_best_val_next;
    logic                          r_out_valid;
    logic                          w_out_valid_next;

    logic signed [DATA_WIDTH-1:0]  w_logit [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0]  w_cur;
    logic signed [DATA_WIDTH-1:0]  w_in0;

    // Unpack the captured vector so the scan can index it by class number.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
            assign w_logit[gi] = r_logits[DATA_WIDTH*gi +: DATA_WIDTH];
        end
        if (NUM_CLASSES > 1) begin : g_sel_multi
            assign w_cur = w_logit[r_cnt];
        end else begin : g_sel_single
            assign w_cur = w_logit[0];
        end
    endgenerate

    assign w_in0 = bus.logits_in[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_logits    <= '0;
            r_cnt       <= '0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_logits    <= w_logits_next;
            r_cnt       <= w_cnt_next;
            r_best_idx  <= w_best_idx_next;
            r_best_val  <= w_best_val_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_logits_next    = r_logits;
        w_cnt_next       = r_cnt;
        w_best_idx_next  = r_best_idx;
        w_best_val_next  = r_best_val;
        w_out_valid_next = r_out_valid;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_logits_next   = bus.logits_in;
                    w_best_val_next = w_in0;
                    w_best_idx_next = '0;
                    w_cnt_next      = ONE_IDX;
                    // A single-class vector is already resolved at capture.
                    if (MULTI) begin
                        w_state_next     = S_SCAN;
                        w_out_valid_next = 1'b0;
                    end else begin
                        w_state_next     = S_DONE;
                        w_out_valid_next = 1'b1;
                    end
                end
            end

            S_SCAN: begin
                // Strict greater-than keeps the lowest index on ties.
                if (w_cur > r_best_val) begin
                    w_best_val_next = w_cur;
                    w_best_idx_next = r_cnt;
                end
                if (r_cnt == LAST_IDX) begin
                    w_state_next     = S_DONE;
                    w_out_valid_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + ONE_IDX;
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.out_valid = r_out_valid;
    assign bus.class_idx = r_best_idx;
    assign bus.max_val   = r_best_val;

endmodule

// File: tb/tb_vit_logits_argmax.sv
// Bench for vit_logits_argmax: a cycle-level reference model checks a
// 4-class instance every cycle; literal cases pin the model and a 1-class build.
module tb_vit_logits_argmax;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vit_logits_argmax_if #(.DATA_WIDTH(W), .NUM_CLASSES(N), .IDX_W(IW)) bus4 ();
    vit_logits_argmax_if #(.DATA_WIDTH(W), .NUM_CLASSES(1), .IDX_W(1))  bus1 ();

    vit_logits_argmax #(.DATA_WIDTH(W), .NUM_CLASSES(N), .IDX_W(IW)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    vit_logits_argmax #(.DATA_WIDTH(W), .NUM_CLASSES(1), .IDX_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                             input logic [W-1:0] a2, input logic [W-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Reference: find the maximum signed value, then the lowest index holding it.
    function automatic void ref_argmax(input logic [N*W-1:0] v, output logic [IW-1:0] idx,
                                       output logic [W-1:0] val);
        logic signed [W-1:0] x;
        int mx;
        x  = v[W-1:0];
        mx = x;
        for (int i = 1; i < N; i++) begin
            x = v[W*i +: W];
            if (int'(x) > mx) mx = x;
        end
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            x = v[W*i +: W];
            if (int'(x) == mx) idx = IW'(i);
        end
        val = W'(mx);
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 4))
                0:       v[W*i +: W] = 16'h8000;
                1:       v[W*i +: W] = 16'h7FFF;
                2:       v[W*i +: W] = 16'h0005;
                3:       v[W*i +: W] = 16'hFFFF;
                default: v[W*i +: W] = W'($urandom);
            endcase
        end
        return v;
    endfunction

    // Model timeline: e counts edges since reset; a request accepted at edge acc
    // is busy through edge acc+N-1, done right after it, and idle again at acc+N.
    int              m_e = 0;
    int              m_acc = 0;
    bit              m_have = 1'b0;
    logic [IW-1:0]   m_idx = '0;
    logic [W-1:0]    m_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have = 1'b0;
            m_e    = 0;
        end else begin
            m_e++;
            if (bus4.start && (!m_have || m_e >= m_acc + N + 1)) begin
                m_acc  = m_e;
                m_have = 1'b1;
                ref_argmax(bus4.logits_in, m_idx, m_val);
            end
        end
    end

    always @(negedge clk) begin
        bit eb, ed, ev;
        eb = m_have && (m_e <= m_acc + N - 1);
        ed = m_have && (m_e == m_acc + N - 1);
        ev = m_have && (m_e >= m_acc + N - 1);
        chk("cyc_busy", 32'(bus4.busy), 32'(eb));
        chk("cyc_done", 32'(bus4.done), 32'(ed));
        chk("cyc_valid", 32'(bus4.out_valid), 32'(ev));
        if (!m_have) begin
            chk("cyc_idx_rst", 32'(bus4.class_idx), 32'd0);
            chk("cyc_val_rst", 32'(bus4.max_val), 32'd0);
        end else if (ev) begin
            chk("cyc_idx", 32'(bus4.class_idx), 32'(m_idx));
            chk("cyc_val", 32'(bus4.max_val), 32'(m_val));
        end
    end

    task automatic run4(input string nm, input logic [N*W-1:0] v,
                        input logic [IW-1:0] ei, input logic [W-1:0] ev);
        int lat;
        @(negedge clk);
        bus4.logits_in = v;
        bus4.start     = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 1;
        while (!bus4.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'd4);
        chk({nm, "_idx"}, 32'(bus4.class_idx), 32'(ei));
        chk({nm, "_val"}, 32'(bus4.max_val), 32'(ev));
        chk({nm, "_valid"}, 32'(bus4.out_valid), 32'd1);
        $display("[TB] %s: idx=%0d val=0x%0h latency=%0d", nm, bus4.class_idx, bus4.max_val, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, nd, first_done;
        int dt[3];
        logic [IW-1:0] hold_idx[3];
        logic [W-1:0]  hold_val[3];

        bus4.start = 1'b0;
        bus4.logits_in = '0;
        bus1.start = 1'b0;
        bus1.logits_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_idx", 32'(bus4.class_idx), 32'd0);
        chk("rst_val", 32'(bus4.max_val), 32'd0);
        chk("rst1_done", 32'(bus1.done), 32'd0);
        rst_n = 1'b1;

        // Basic scan, then hold for 10 idle cycles.
        run4("basic", pack4(16'h0010, 16'h0200, 16'h0050, 16'h0100), 2'd1, 16'h0200);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus4.out_valid), 32'd1);
            chk("hold_idx", 32'(bus4.class_idx), 32'd1);
            chk("hold_val", 32'(bus4.max_val), 32'h0200);
        end

        run4("signed", pack4(16'hFFF0, 16'h8000, 16'hFFF0, 16'hFFFF), 2'd3, 16'hFFFF);
        run4("tie", pack4(16'd5, 16'd5, 16'd5, 16'd5), 2'd0, 16'd5);

        // Re-pulse start mid-scan and corrupt the input vector.
        @(negedge clk);
        bus4.logits_in = pack4(16'h0001, 16'h0002, 16'h0300, 16'h0004);
        bus4.start = 1'b1;
        nd = 0;
        first_done = 0;
        for (c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus4.start = (c == 2);
            if (c == 2) bus4.logits_in = {N{16'h7FFF}};
            if (bus4.done) begin
                nd++;
                if (first_done == 0) begin
                    first_done = c;
                    chk("repulse_idx", 32'(bus4.class_idx), 32'd2);
                    chk("repulse_val", 32'(bus4.max_val), 32'h0300);
                end
            end
        end
        chk("repulse_ndone", 32'(nd), 32'd1);
        chk("repulse_lat", 32'(first_done), 32'd4);
        $display("[TB] repulse: dones=%0d first_at=%0d", nd, first_done);

        // Asynchronous reset between edges in the middle of a scan.
        @(negedge clk);
        bus4.logits_in = pack4(16'h0009, 16'h0008, 16'h0007, 16'h0006);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus4.busy), 32'd0);
        chk("arst_done", 32'(bus4.done), 32'd0);
        chk("arst_valid", 32'(bus4.out_valid), 32'd0);
        chk("arst_idx", 32'(bus4.class_idx), 32'd0);
        chk("arst_val", 32'(bus4.max_val), 32'd0);
        $display("[TB] async reset mid-scan: busy=%0d valid=%0d", bus4.busy, bus4.out_valid);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run4("post_rst", pack4(16'h8000, 16'h0001, 16'h0002, 16'h7FFF), 2'd3, 16'h7FFF);

        // start held high across three back-to-back requests.
        hold_idx[0] = 2'd1; hold_val[0] = 16'h0040;
        hold_idx[1] = 2'd0; hold_val[1] = 16'h0070;
        hold_idx[2] = 2'd3; hold_val[2] = 16'h0011;
        @(negedge clk);
        bus4.logits_in = pack4(16'h0001, 16'h0040, 16'h0003, 16'h0004);
        bus4.start = 1'b1;
        nd = 0;
        for (c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 6 || c == 11) chk("held_valid_drop", 32'(bus4.out_valid), 32'd0);
            if (bus4.done) begin
                if (nd < 3) begin
                    dt[nd] = c;
                    chk("held_idx", 32'(bus4.class_idx), 32'(hold_idx[nd]));
                    chk("held_val", 32'(bus4.max_val), 32'(hold_val[nd]));
                    $display("[TB] held req %0d: done_at=%0d idx=%0d val=0x%0h",
                             nd, c, bus4.class_idx, bus4.max_val);
                end
                nd++;
            end
            if (c == 1)  bus4.logits_in = pack4(16'h0070, 16'h0001, 16'h0002, 16'h0003);
            if (c == 6)  bus4.logits_in = pack4(16'h0000, 16'h0000, 16'h0000, 16'h0011);
            if (c == 11) bus4.start = 1'b0;
        end
        chk("held_ndone", 32'(nd), 32'd3);
        if (nd >= 3) begin
            chk("held_first", 32'(dt[0]), 32'd4);
            chk("held_gap1", 32'(dt[1] - dt[0]), 32'd5);
            chk("held_gap2", 32'(dt[2] - dt[1]), 32'd5);
        end

        // Randomized traffic: requests at random times, inputs churning.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus4.start = ($urandom_range(0, 3) == 0);
            bus4.logits_in = rand_vec();
            if (bus4.done)
                $display("[TB] rand done: idx=%0d val=0x%0h", bus4.class_idx, bus4.max_val);
        end
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (8) @(negedge clk);

        // Single-class build: result in the cycle after the accepting edge.
        @(negedge clk);
        bus1.logits_in = 16'h1234;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.logits_in = 16'h7777;
        chk("n1_done", 32'(bus1.done), 32'd1);
        chk("n1_busy", 32'(bus1.busy), 32'd1);
        chk("n1_valid", 32'(bus1.out_valid), 32'd1);
        chk("n1_idx", 32'(bus1.class_idx), 32'd0);
        chk("n1_val", 32'(bus1.max_val), 32'h1234);
        $display("[TB] n1: done=%0d val=0x%0h", bus1.done, bus1.max_val);
        @(negedge clk);
        chk("n1_done_pulse", 32'(bus1.done), 32'd0);
        chk("n1_idle", 32'(bus1.busy), 32'd0);
        chk("n1_hold_valid", 32'(bus1.out_valid), 32'd1);
        chk("n1_hold_val", 32'(bus1.max_val), 32'h1234);
        @(negedge clk);
        bus1.logits_in = 16'h8000;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        chk("n1_neg_done", 32'(bus1.done), 32'd1);
        chk("n1_neg_val", 32'(bus1.max_val), 32'h8000);
        $display("[TB] n1: done=%0d val=0x%0h", bus1.done, bus1.max_val);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
